// File: rtl/pipe_pkg.sv
// pipe_pkg: shared defaults and the inter-stage packet layout for the decode->execute path
package pipe_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int PC_W_DEF = 16;
  localparam int MAX_OPS = 4;
  typedef struct packed {
    logic [PC_W_DEF-1:0] pc;
    logic [MAX_OPS*DATA_W_DEF-1:0] ops;
  } stage_pkt_t;
endpackage

// File: rtl/decode_execute_skid_stage_sat_counter.sv
// sat_counter: adds 0..3 per cycle and sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic [1:0]       inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W+1:0] sum;
  assign sum = (CNT_W+2)'(cnt_q) + (CNT_W+2)'(inc_i);
  assign cnt_d = |sum[CNT_W+1:CNT_W] ? '1 : sum[CNT_W-1:0];
  assign cnt_o = cnt_q;
  always_ff @(posedge clk)
    cnt_q <= clear_i ? '0 : cnt_d;
endmodule

// File: rtl/decode_execute_skid_stage.sv
// decode_execute_skid_stage: decode->execute register with a 2-entry skid buffer, stall/dump control
// and saturating flush/stall counters; up_ready is registered so downstream has no path upstream.
module decode_execute_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W = PC_W_DEF,
  parameter int NUM_OPS = 2,
  parameter int CNT_W = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      up_valid,
  output logic                      up_ready,
  input  logic [PC_W-1:0]           up_pc,
  input  logic [NUM_OPS*DATA_W-1:0] up_ops,
  input  logic                      stall,
  input  logic                      dump,
  output logic                      dn_valid,
  input  logic                      dn_ready,
  output logic [PC_W-1:0]           dn_pc,
  output logic [NUM_OPS*DATA_W-1:0] dn_ops,
  output logic [CNT_W-1:0]          flush_cnt,
  output logic [CNT_W-1:0]          stall_cnt
);
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [NUM_OPS*DATA_W-1:0] ops;
  } pkt_t;
  pkt_t main_q, main_d, skid_q, skid_d, up_pkt;
  logic main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic acc, cons;
  assign up_pkt = {up_pc, up_ops};
  assign up_ready = !skid_v_q;
  assign dn_valid = main_v_q;
  assign dn_pc = main_q.pc;
  assign dn_ops = main_q.ops;
  assign acc = up_valid && up_ready;
  assign cons = main_v_q && dn_ready && !stall;
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (dump) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (cons && skid_v_q) begin
      main_d = skid_q;
      skid_v_d = 1'b0;
    end else if (cons && acc) begin
      main_d = up_pkt;
    end else if (cons) begin
      main_v_d = 1'b0;
    end else if (acc && !main_v_q) begin
      main_d = up_pkt;
      main_v_d = 1'b1;
    end else if (acc) begin
      skid_d = up_pkt;
      skid_v_d = 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end
  // flushed amount is the popcount of the two valid bits
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clock),
    .clear_i(reset),
    .inc_i(dump ? {main_v_q && skid_v_q, main_v_q ^ skid_v_q} : 2'd0),
    .cnt_o(flush_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clock),
    .clear_i(reset),
    .inc_i({1'b0, main_v_q && (stall || !dn_ready)}),
    .cnt_o(stall_cnt)
  );
endmodule

// File: tb/tb_decode_execute_skid_stage.sv
// tb_decode_execute_skid_stage: directed checks of handshake, skid, stall, dump, counters and reset
module tb_decode_execute_skid_stage;
  logic clock = 1'b0;
  logic reset, up_valid, stall, dump, dn_ready;
  logic [15:0] up_pc;
  logic [63:0] up_ops;
  logic up_ready, dn_valid, up_ready2, dn_valid2;
  logic [15:0] dn_pc, dn_pc2, flush_cnt, stall_cnt;
  logic [63:0] dn_ops, dn_ops2;
  logic [1:0] flush_cnt2, stall_cnt2;
  int total = 0;
  int fails = 0;

  always #5 clock = ~clock;

  decode_execute_skid_stage #(.DATA_W(32), .PC_W(16), .NUM_OPS(2), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .up_valid(up_valid), .up_ready(up_ready), .up_pc(up_pc),
    .up_ops(up_ops), .stall(stall), .dump(dump), .dn_valid(dn_valid), .dn_ready(dn_ready),
    .dn_pc(dn_pc), .dn_ops(dn_ops), .flush_cnt(flush_cnt), .stall_cnt(stall_cnt)
  );

  decode_execute_skid_stage #(.DATA_W(32), .PC_W(16), .NUM_OPS(2), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .up_valid(up_valid), .up_ready(up_ready2), .up_pc(up_pc),
    .up_ops(up_ops), .stall(stall), .dump(dump), .dn_valid(dn_valid2), .dn_ready(dn_ready),
    .dn_pc(dn_pc2), .dn_ops(dn_ops2), .flush_cnt(flush_cnt2), .stall_cnt(stall_cnt2)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] pc);
    up_valid = 1'b1;
    up_pc = pc;
    up_ops = {32'(pc) + 32'h100, 32'(pc)};
  endtask

  initial begin
    reset = 1'b1; up_valid = 1'b0; stall = 1'b0; dump = 1'b0; dn_ready = 1'b0;
    up_pc = '0; up_ops = '0;
    step();
    step();
    reset = 1'b0;
    chk("rst_dn_valid", 64'(dn_valid), 64'd0);
    chk("rst_up_ready", 64'(up_ready), 64'd1);
    chk("rst_dn_pc", 64'(dn_pc), 64'd0);
    chk("rst_dn_ops", dn_ops, 64'd0);
    chk("rst_flush", 64'(flush_cnt), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    // streaming with downstream always ready
    dn_ready = 1'b1;
    up_valid = 1'b1; up_pc = 16'h0010; up_ops = {32'hA, 32'hB};
    step();
    up_valid = 1'b0;
    chk("s_dn_valid", 64'(dn_valid), 64'd1);
    chk("s_dn_pc", 64'(dn_pc), 64'h10);
    chk("s_dn_ops", dn_ops, {32'hA, 32'hB});
    chk("s_up_ready", 64'(up_ready), 64'd1);
    step();
    chk("s_drain", 64'(dn_valid), 64'd0);
    chk("s_stall", 64'(stall_cnt), 64'd0);
    // backpressure fills main then skid
    dn_ready = 1'b0;
    push(16'h20);
    step();
    chk("bp_main_pc", 64'(dn_pc), 64'h20);
    chk("bp_rdy1", 64'(up_ready), 64'd1);
    push(16'h24);
    step();
    chk("bp_rdy0", 64'(up_ready), 64'd0);
    chk("bp_main_hold", 64'(dn_pc), 64'h20);
    push(16'h28);
    step();
    chk("bp_still_full", 64'(up_ready), 64'd0);
    chk("bp_pc_hold", 64'(dn_pc), 64'h20);
    chk("bp_ops_hold", dn_ops, {32'h120, 32'h20});
    dn_ready = 1'b1;
    step();
    chk("rel_pc24", 64'(dn_pc), 64'h24);
    chk("rel_v24", 64'(dn_valid), 64'd1);
    chk("rel_rdy", 64'(up_ready), 64'd1);
    step();
    up_valid = 1'b0;
    chk("rel_pc28", 64'(dn_pc), 64'h28);
    chk("rel_ops28", dn_ops, {32'h128, 32'h28});
    step();
    chk("rel_empty", 64'(dn_valid), 64'd0);
    chk("bp_stall_cnt", 64'(stall_cnt), 64'd2);
    // stall freezes output and the new packet lands in skid
    push(16'h30);
    step();
    stall = 1'b1;
    push(16'h34);
    step();
    up_valid = 1'b0;
    chk("st_pc1", 64'(dn_pc), 64'h30);
    step();
    chk("st_pc2", 64'(dn_pc), 64'h30);
    step();
    chk("st_pc3", 64'(dn_pc), 64'h30);
    chk("st_valid", 64'(dn_valid), 64'd1);
    chk("st_cnt", 64'(stall_cnt), 64'd5);
    chk("st_skid_full", 64'(up_ready), 64'd0);
    // dump with both entries held and an offered packet
    stall = 1'b0; dump = 1'b1;
    push(16'h38);
    step();
    dump = 1'b0; up_valid = 1'b0;
    chk("d_valid", 64'(dn_valid), 64'd0);
    chk("d_rdy", 64'(up_ready), 64'd1);
    chk("d_flush", 64'(flush_cnt), 64'd2);
    chk("d_stall", 64'(stall_cnt), 64'd5);
    step();
    chk("d_not_fwd", 64'(dn_valid), 64'd0);
    // a packet accepted in the dump cycle is discarded
    dump = 1'b1;
    push(16'h3C);
    step();
    dump = 1'b0; up_valid = 1'b0;
    chk("d_acc_drop", 64'(dn_valid), 64'd0);
    chk("d_acc_flush", 64'(flush_cnt), 64'd2);
    // dump and stall together with one entry
    push(16'h40);
    step();
    up_valid = 1'b0; dump = 1'b1; stall = 1'b1;
    step();
    dump = 1'b0; stall = 1'b0;
    chk("ds_valid", 64'(dn_valid), 64'd0);
    chk("ds_flush", 64'(flush_cnt), 64'd3);
    chk("ds_stall", 64'(stall_cnt), 64'd6);
    // reset while skid holds a packet
    dn_ready = 1'b0;
    push(16'h50);
    step();
    push(16'h54);
    step();
    up_valid = 1'b0;
    chk("r_pre_full", 64'(up_ready), 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("r_valid", 64'(dn_valid), 64'd0);
    chk("r_rdy", 64'(up_ready), 64'd1);
    chk("r_flush", 64'(flush_cnt), 64'd0);
    chk("r_stall", 64'(stall_cnt), 64'd0);
    chk("r_stall2", 64'(stall_cnt2), 64'd0);
    step();
    chk("r_no_leak", 64'(dn_valid), 64'd0);
    // saturation on the 2-bit counter instance
    dn_ready = 1'b1;
    push(16'h60);
    step();
    up_valid = 1'b0; stall = 1'b1;
    step();
    chk("sat1", 64'(stall_cnt2), 64'd1);
    step();
    chk("sat2", 64'(stall_cnt2), 64'd2);
    step();
    chk("sat3", 64'(stall_cnt2), 64'd3);
    step();
    chk("sat4", 64'(stall_cnt2), 64'd3);
    step();
    chk("sat5", 64'(stall_cnt2), 64'd3);
    chk("sat_wide", 64'(stall_cnt), 64'd5);
    chk("sat_pc", 64'(dn_pc2), 64'h60);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
